uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL provide parameter CLKS_PER_BIT, default 434, meaning clk cycles per bit (50 MHz / 115200), legal range 4..65535.
REQ-002 The block SHALL provide parameter DATA_BITS, default 8, meaning data bits per frame, fixed at 8 in this release.
REQ-003 The block SHALL provide port clk, input, 1, meaning the sole clock, with all logic on its rising edge.
REQ-004 The block SHALL provide port rst, input, 1, meaning the reset; it is synchronous and active-high.
REQ-005 The block SHALL provide port rx_i, input, 1, meaning the asynchronous serial line (8N1, idle high), the counterpart of core uart_tx_o.
REQ-006 The block SHALL provide port rx_data_o, output, 8, meaning the received byte, valid while rx_valid_o=1.
REQ-007 The block SHALL provide port rx_valid_o, output, 1, meaning the holding register contains an unconsumed byte.
REQ-008 The block SHALL provide port rx_ready_i, input, 1, meaning the consumer accepts the byte; a transfer occurs when rx_valid_o and rx_ready_i are both 1 on a clk edge.
REQ-009 The block SHALL provide port frame_err_o, output, 1, meaning a one-cycle pulse when the stop bit is sampled low.
REQ-010 The block SHALL provide port overrun_o, output, 1, meaning a one-cycle pulse when a good byte is dropped because the holding register is full.
REQ-011 The block SHALL provide port busy_o, output, 1, meaning the FSM state is not IDLE.

Function
REQ-012 rx_i SHALL pass through a 2-flop synchronizer before use, giving 2 cycles of input latency.
REQ-013 The FSM SHALL have states IDLE, START, DATA, STOP and BREAK, and SHALL use one 16-bit cycle counter and one 3-bit bit index.
REQ-014 In IDLE, a synchronized low SHALL move the FSM to START and clear the counter.
REQ-015 In START, at counter = CLKS_PER_BIT/2 - 1 (floor), the FSM SHALL go to DATA if the line is low, otherwise return to IDLE (glitch rejected); the counter SHALL clear in both cases.
REQ-016 In DATA, at each counter = CLKS_PER_BIT - 1, the block SHALL sample the line into the shift register LSB-first, increment the bit index and clear the counter; after bit index 7 it SHALL enter STOP.
REQ-017 In STOP, at counter = CLKS_PER_BIT - 1: a high line SHALL deliver the byte and return to IDLE; a low line SHALL pulse frame_err_o the next cycle, discard the byte and enter BREAK.
REQ-018 BREAK SHALL remain until the synchronized line is high, then go to IDLE.
REQ-019 Delivery SHALL load rx_data_o and set rx_valid_o on the edge following the stop-bit sample, if rx_valid_o=0 or a transfer occurs on that same edge.
REQ-020 If rx_valid_o=1 and no transfer occurs on the delivery edge, the new byte SHALL be dropped, rx_data_o SHALL be retained, and overrun_o SHALL pulse.
REQ-021 A transfer without a simultaneous delivery SHALL clear rx_valid_o on that edge.
REQ-022 rx_data_o SHALL remain stable while rx_valid_o=1.
REQ-023 The FSM SHALL be ready for the next start bit in the cycle after the stop-bit sample, so back-to-back frames are received with no gap.
REQ-024 frame_err_o and overrun_o SHALL never be high in the same cycle, and SHALL never assert for longer than 1 cycle.

Reset
REQ-025 While rst=1, on each clk edge the FSM SHALL be set to IDLE, the counter and bit index to 0, the shift register to 0, both synchronizer flops to 1, and rx_data_o to 0x00.
REQ-026 While rst=1, on each clk edge rx_valid_o, frame_err_o, overrun_o and busy_o SHALL be set to 0.
REQ-027 A reset asserted mid-frame SHALL abandon the frame with no output pulse.
REQ-028 After a mid-frame reset, the remaining bits of the abandoned frame SHALL be treated as fresh line activity.

Structure
REQ-029 Shared package uart_pkg SHALL hold the FSM state encoding (IDLE=0, START=1, DATA=2, STOP=3, BREAK=4) and DATA_BITS.
REQ-030 The package SHALL be reused by the existing transmitter.
REQ-031 The synchronizer SHALL be a sub-module, sync_2ff (reset value parameter, here 1).
REQ-032 All other logic SHALL reside in uart_rx.

Verification (CLKS_PER_BIT=16, rx_ready_i=1 unless stated)
REQ-033 Frame 0x55 -> rx_valid_o is 1 for exactly 1 cycle, rx_data_o=0x55, and there are no error pulses.
REQ-034 A 4-cycle low glitch on an idle line -> busy_o rises then falls, with no rx_valid_o, frame_err_o or overrun_o.
REQ-035 Frame 0xA3 with the stop bit low, the line then held low 40 cycles and then high -> one frame_err_o pulse, no rx_valid_o, busy_o=1 until 2 cycles after the line rises, then frame 0x3C is received correctly.
REQ-036 rx_ready_i=0 with frames 0x11 then 0x22 -> rx_data_o=0x11 held, one overrun_o pulse at the second stop, then rx_ready_i=1 for 1 cycle -> rx_valid_o clears.
REQ-037 rst pulsed for 1 cycle mid-data of frame 0xFF, then frame 0x81 -> all outputs are 0 after reset, no pulse is produced for the abandoned frame, and 0x81 is received correctly.
REQ-038 Three back-to-back frames 0x01, 0x80, 0xC3 with zero idle time -> three rx_valid_o pulses in order, each 160 cycles apart.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM state encoding and frame width.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StStart = 3'd1,
        StData  = 3'd2,
        StStop  = 3'd3,
        StBreak = 3'd4
    } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with a configurable reset value.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= d_i;
            r_sync <= r_meta;
        end
    end

    assign q_o = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, a one-deep valid/ready holding register,
// framing-error and overrun pulses.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned DATA_BITS    = uart_pkg::DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic                 frame_err_o,
    output logic                 overrun_o,
    output logic                 busy_o
);

    import uart_pkg::*;

    localparam logic [15:0] CNT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] CNT_HALF  = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]  BIT_LAST  = 3'(DATA_BITS - 1);

    logic                 w_rx;
    uart_state_e          r_state;
    logic [15:0]          r_cnt;
    logic [2:0]           r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_deliver;
    logic                 r_frame_err;
    logic                 r_busy;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_overrun;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx_i),
        .q_o (w_rx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_deliver   <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_deliver   <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (!w_rx) begin
                        r_state <= StStart;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                StStart: begin
                    if (r_cnt == CNT_HALF) begin
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                        // A start bit that has gone high again by mid-bit was a glitch.
                        if (!w_rx) begin
                            r_state <= StData;
                        end else begin
                            r_state <= StIdle;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                StData: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt     <= '0;
                        r_shift   <= {w_rx, r_shift[DATA_BITS-1:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == BIT_LAST) begin
                            r_state <= StStop;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                StStop: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt <= '0;
                        if (w_rx) begin
                            r_deliver <= 1'b1;
                            r_state   <= StIdle;
                            r_busy    <= 1'b0;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= StBreak;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                StBreak: begin
                    if (w_rx) begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Holding register: a delivery wins over a plain transfer, and is dropped when full.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (r_deliver) begin
                if (!r_valid || rx_ready_i) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && rx_ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_data_o   = r_data;
    assign rx_valid_o  = r_valid;
    assign frame_err_o = r_frame_err;
    assign overrun_o   = r_overrun;
    assign busy_o      = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a frame-level timing model plus directed scenarios.
module tb_uart_rx;

    localparam int unsigned CPB = 16;
    // Start edge -> error pulse: 2 sync + half bit + start/8 data bits remaining; +1 to deliver.
    localparam int unsigned LAT_ERR = 2 + CPB / 2 + 9 * CPB;
    localparam int unsigned LAT_DLV = LAT_ERR + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_i = 1'b1;
    logic       rx_ready_i = 1'b1;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       frame_err_o;
    logic       overrun_o;
    logic       busy_o;

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_i        (rx_i),
        .rx_data_o   (rx_data_o),
        .rx_valid_o  (rx_valid_o),
        .rx_ready_i  (rx_ready_i),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned at;
        bit          err;
        logic [7:0]  data;
    } ev_t;

    typedef struct {
        int unsigned at;
        logic [7:0]  data;
    } obs_t;

    int unsigned cyc = 0;
    int unsigned tests = 0;
    int unsigned fails = 0;
    ev_t         sched[$];
    obs_t        obs[$];
    logic        exp_valid = 1'b0;
    logic        exp_ferr = 1'b0;
    logic        exp_ovr = 1'b0;
    logic [7:0]  exp_data = 8'h00;
    bit          chk_en = 1'b0;
    logic        prev_valid = 1'b0;
    int unsigned ferr_cnt = 0;
    int unsigned ovr_cnt = 0;
    int unsigned busy_cnt = 0;
    int unsigned valid_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic wait_cycles(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one 8N1 frame; must be called #1 after an edge. e0 = first edge seeing the start bit.
    task automatic send_frame(input logic [7:0] d, input logic stop, output int unsigned e0);
        logic [9:0] bits;
        ev_t        ev;
        bits    = {stop, d, 1'b0};
        e0      = cyc + 1;
        ev.at   = e0 + (stop ? LAT_DLV : LAT_ERR);
        ev.err  = !stop;
        ev.data = d;
        sched.push_back(ev);
        for (int k = 0; k < 10; k++) begin
            rx_i = bits[k];
            wait_cycles(CPB);
        end
    endtask

    // Frame-level model: scheduled deliveries/errors applied to a one-deep valid/ready buffer.
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        exp_ferr <= 1'b0;
        exp_ovr  <= 1'b0;
        if (rst) begin
            exp_valid <= 1'b0;
            exp_data  <= 8'h00;
            sched.delete();
        end else begin
            if (sched.size() > 0 && sched[0].at == cyc + 1 && !sched[0].err) begin
                if (!exp_valid || rx_ready_i) begin
                    exp_valid <= 1'b1;
                    exp_data  <= sched[0].data;
                end else begin
                    exp_ovr <= 1'b1;
                end
            end else if (exp_valid && rx_ready_i) begin
                exp_valid <= 1'b0;
            end
            if (sched.size() > 0 && sched[0].at == cyc + 1) begin
                if (sched[0].err) exp_ferr <= 1'b1;
                void'(sched.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rx_valid_o", {31'd0, rx_valid_o}, {31'd0, exp_valid});
            if (exp_valid) chk("rx_data_o", {24'd0, rx_data_o}, {24'd0, exp_data});
            chk("frame_err_o", {31'd0, frame_err_o}, {31'd0, exp_ferr});
            chk("overrun_o", {31'd0, overrun_o}, {31'd0, exp_ovr});
            chk("err_exclusive", {31'd0, frame_err_o & overrun_o}, 32'd0);
            if (rx_valid_o && !prev_valid) obs.push_back('{at: cyc, data: rx_data_o});
            prev_valid = rx_valid_o;
            if (frame_err_o) ferr_cnt++;
            if (overrun_o) ovr_cnt++;
            if (busy_o) busy_cnt++;
            if (rx_valid_o) valid_cnt++;
        end
    end

    task automatic clear_counts();
        obs.delete();
        ferr_cnt  = 0;
        ovr_cnt   = 0;
        busy_cnt  = 0;
        valid_cnt = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, {31'd0, rx_valid_o}, 32'd0);
        chk({tag, "_data"}, {24'd0, rx_data_o}, 32'd0);
        chk({tag, "_ferr"}, {31'd0, frame_err_o}, 32'd0);
        chk({tag, "_ovr"}, {31'd0, overrun_o}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
    endtask

    initial begin
        int unsigned e0;
        int unsigned e1;

        rst = 1'b1;
        wait_cycles(3);
        chk_all_zero("reset");
        rst    = 1'b0;
        chk_en = 1'b1;
        wait_cycles(20);

        // Single frame 0x55.
        clear_counts();
        send_frame(8'h55, 1'b1, e0);
        wait_cycles(20);
        chk("x55_count", obs.size(), 32'd1);
        if (obs.size() == 1) begin
            chk("x55_data", {24'd0, obs[0].data}, 32'h55);
            chk("x55_latency", obs[0].at - e0, 32'd155);
        end
        chk("x55_valid_cycles", valid_cnt, 32'd1);
        chk("x55_errs", ferr_cnt + ovr_cnt, 32'd0);

        // 4-cycle glitch: busy for half a bit, then back to idle.
        clear_counts();
        rx_i = 1'b0;
        wait_cycles(4);
        rx_i = 1'b1;
        wait_cycles(30);
        chk("glitch_busy_cycles", busy_cnt, 32'd8);
        chk("glitch_busy_end", {31'd0, busy_o}, 32'd0);
        chk("glitch_no_output", obs.size() + ferr_cnt + ovr_cnt, 32'd0);

        // Framing error, held break, then recovery with 0x3C.
        clear_counts();
        send_frame(8'hA3, 1'b0, e0);
        wait_cycles(40);
        rx_i = 1'b1;
        wait_cycles(2);
        chk("break_busy_hold", {31'd0, busy_o}, 32'd1);
        wait_cycles(1);
        chk("break_busy_drop", {31'd0, busy_o}, 32'd0);
        chk("break_ferr_count", ferr_cnt, 32'd1);
        chk("break_no_valid", obs.size(), 32'd0);
        wait_cycles(10);
        send_frame(8'h3C, 1'b1, e0);
        wait_cycles(20);
        chk("x3c_count", obs.size(), 32'd1);
        if (obs.size() == 1) chk("x3c_data", {24'd0, obs[0].data}, 32'h3C);

        // Overrun with the consumer stalled.
        clear_counts();
        rx_ready_i = 1'b0;
        send_frame(8'h11, 1'b1, e0);
        send_frame(8'h22, 1'b1, e1);
        wait_cycles(20);
        chk("ovr_valid_held", {31'd0, rx_valid_o}, 32'd1);
        chk("ovr_data_held", {24'd0, rx_data_o}, 32'h11);
        chk("ovr_pulses", ovr_cnt, 32'd1);
        rx_ready_i = 1'b1;
        wait_cycles(1);
        chk("ovr_drain", {31'd0, rx_valid_o}, 32'd0);
        wait_cycles(10);

        // Reset mid-data of 0xFF, then 0x81.
        clear_counts();
        fork
            send_frame(8'hFF, 1'b1, e0);
            begin
                wait_cycles(60);
                rst = 1'b1;
                wait_cycles(1);
                chk_all_zero("midrst");
                rst = 1'b0;
            end
        join
        wait_cycles(20);
        chk("midrst_no_pulse", obs.size() + ferr_cnt + ovr_cnt, 32'd0);
        send_frame(8'h81, 1'b1, e0);
        wait_cycles(20);
        chk("x81_count", obs.size(), 32'd1);
        if (obs.size() == 1) chk("x81_data", {24'd0, obs[0].data}, 32'h81);

        // Back-to-back frames with no idle time.
        clear_counts();
        send_frame(8'h01, 1'b1, e0);
        send_frame(8'h80, 1'b1, e1);
        send_frame(8'hC3, 1'b1, e1);
        wait_cycles(20);
        chk("b2b_count", obs.size(), 32'd3);
        if (obs.size() == 3) begin
            chk("b2b_data0", {24'd0, obs[0].data}, 32'h01);
            chk("b2b_data1", {24'd0, obs[1].data}, 32'h80);
            chk("b2b_data2", {24'd0, obs[2].data}, 32'hC3);
            chk("b2b_gap01", obs[1].at - obs[0].at, 32'd160);
            chk("b2b_gap12", obs[2].at - obs[1].at, 32'd160);
        end
        chk("b2b_errs", ferr_cnt + ovr_cnt, 32'd0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
